// File: rtl/fifo_rd_stream.sv
// Read-domain output stage of the async FIFO: pops words into a two-entry
// skid buffer, presents them as a registered valid/ready stream, and reports
// a registered fill level and almost-empty flag from the Gray pointers.
module fifo_rd_stream #(
  parameter int unsigned DATA_SIZE     = 8,
  parameter int unsigned ADDRESS_SIZE  = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    rempty,
  input  logic [DATA_SIZE-1:0]    rdata,
  input  logic [ADDRESS_SIZE:0]   read_ptr,
  input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
  output logic                    rinc,
  output logic [DATA_SIZE-1:0]    m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [ADDRESS_SIZE:0]   rlevel,
  output logic                    ralmost_empty
);

  localparam int unsigned PTR_W = ADDRESS_SIZE + 1;

  // Occupancy of the skid buffer: nothing, main only, main and skid.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_SIZE-1:0] r_main;
  logic [DATA_SIZE-1:0] r_skid;
  logic [DATA_SIZE-1:0] w_main_nxt;
  logic [DATA_SIZE-1:0] w_skid_nxt;
  logic                 r_tvalid;
  logic                 w_pop;
  logic                 w_acc;
  logic [PTR_W-1:0]     w_rbin;
  logic [PTR_W-1:0]     w_wbin;
  logic [PTR_W-1:0]     w_level;
  logic                 w_aempty;
  logic [PTR_W-1:0]     r_level;
  logic                 r_aempty;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pop only from registered state so m_tready never reaches rinc.
  assign w_pop = !rempty && (r_state != S2);
  assign w_acc = r_tvalid && m_tready;

  // Next-state and next-data selection for the skid buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S0: begin
        if (w_pop) begin
          w_state_nxt = S1;
          w_main_nxt  = rdata;
        end
      end
      S1: begin
        if (w_pop && w_acc) begin
          w_main_nxt = rdata;
        end else if (w_pop) begin
          w_state_nxt = S2;
          w_skid_nxt  = rdata;
        end else if (w_acc) begin
          w_state_nxt = S0;
        end
      end
      S2: begin
        if (w_acc) begin
          w_state_nxt = S1;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = S0;
      end
    endcase
  end

  // Skid buffer state and data registers; reset discards held words.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state  <= S0;
      r_main   <= '0;
      r_skid   <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_main   <= w_main_nxt;
      r_skid   <= w_skid_nxt;
      r_tvalid <= (w_state_nxt != S0);
    end
  end

  // Modulo subtraction of binary pointers handles the MSB wrap.
  assign w_rbin   = gray2bin(read_ptr);
  assign w_wbin   = gray2bin(rq2_write_ptr);
  assign w_level  = w_wbin - w_rbin;
  assign w_aempty = (w_level <= PTR_W'(AEMPTY_THRESH));

  // Registered fill level and almost-empty flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_level  <= '0;
      r_aempty <= 1'b1;
    end else begin
      r_level  <= w_level;
      r_aempty <= w_aempty;
    end
  end

  assign rinc          = w_pop;
  assign m_tdata       = r_main;
  assign m_tvalid      = r_tvalid;
  assign rlevel        = r_level;
  assign ralmost_empty = r_aempty;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: models the FIFO memory, read pointer/empty logic
// and a two-flop write-pointer synchronizer, scoreboarding words in order.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic [4:0] read_ptr;
  logic [4:0] rq2_write_ptr;
  logic       rinc;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [4:0] rlevel;
  logic       ralmost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model state
  logic [7:0] mem [16];
  logic [4:0] rbin;
  logic [4:0] rbin_nxt;
  logic [4:0] wbin;
  logic [4:0] wq1;
  logic [4:0] wq2;
  logic       manual;
  logic [4:0] man_r;
  logic [4:0] man_w;
  logic [7:0] sb [$];

  fifo_rd_stream #(
    .DATA_SIZE    (8),
    .ADDRESS_SIZE (4),
    .AEMPTY_THRESH(2)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .rempty       (rempty),
    .rdata        (rdata),
    .read_ptr     (read_ptr),
    .rq2_write_ptr(rq2_write_ptr),
    .rinc         (rinc),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .rlevel       (rlevel),
    .ralmost_empty(ralmost_empty)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  assign rdata         = mem[rbin[3:0]];
  assign rbin_nxt      = rbin + {4'b0, (rinc & ~rempty)};
  assign read_ptr      = manual ? man_r : gray(rbin);
  assign rq2_write_ptr = manual ? man_w : wq2;

  // Read pointer / empty logic and write pointer synchronizer model.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rempty <= 1'b1;
      wq1    <= '0;
      wq2    <= '0;
    end else begin
      rbin   <= rbin_nxt;
      rempty <= (gray(rbin_nxt) == wq2);
      wq1    <= gray(wbin);
      wq2    <= wq1;
    end
  end

  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    wbin = wbin + 5'd1;
    sb.push_back(d);
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      if (c == 3) rrst_n = 1'b1;
      #1;
      n_checks++;
      if (rinc !== 1'b0 || m_tvalid !== 1'b0 || rlevel !== 5'd0 ||
          ralmost_empty !== 1'b1 || m_tdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: rinc=%b tvalid=%b rlevel=%0d ae=%b tdata=%h, required 0 0 0 1 00",
                 c, rinc, m_tvalid, rlevel, ralmost_empty, m_tdata);
      end
    end
  endtask

  task automatic test_streaming();
    int   fall  = -1;
    int   first = -1;
    int   gaps  = 0;
    int   got   = 0;
    logic [7:0] exp;
    @(negedge rclk);
    m_tready = 1'b1;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      #1;
      if (rempty === 1'b0 && fall < 0) fall = c;
      if (m_tvalid === 1'b1 && first < 0) first = c;
      if (first >= 0 && m_tvalid !== 1'b1 && sb.size() > 0) gaps++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got %h, required no word", m_tdata);
        end else begin
          exp = sb.pop_front();
          got++;
          if (m_tdata !== exp) begin
            n_fail++;
            $display("FAIL stream_data: got %h required %h", m_tdata, exp);
          end
        end
      end
    end
    n_checks++;
    if (first - fall != 1 || fall < 0) begin
      n_fail++;
      $display("FAIL stream_latency: tvalid-rempty_fall=%0d required 1", first - fall);
    end
    n_checks++;
    if (gaps != 0 || got != 16) begin
      n_fail++;
      $display("FAIL stream_gaps: gaps=%0d words=%0d required 0 and 16", gaps, got);
    end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int got    = 0;
    logic [7:0] exp;
    @(negedge rclk);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      #1;
      if (rinc === 1'b1) pulses++;
      if (m_tvalid === 1'b1) begin
        n_checks++;
        if (m_tdata !== 8'hA0) begin
          n_fail++;
          $display("FAIL bp_stable: got %h required a0", m_tdata);
        end
      end
    end
    n_checks++;
    if (pulses != 2 || rinc !== 1'b0 || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pops: pulses=%0d rinc=%b tvalid=%b required 2 0 1", pulses, rinc, m_tvalid);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      m_tready = 1'b1;
      #1;
      if (m_tvalid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_dup: got %h, required no word", m_tdata);
        end else begin
          exp = sb.pop_front();
          got++;
          if (m_tdata !== exp) begin
            n_fail++;
            $display("FAIL bp_order: got %h required %h", m_tdata, exp);
          end
        end
      end
    end
    n_checks++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words required 5", got);
    end
  endtask

  task automatic test_random_ready();
    int   sent = 0;
    int   recv = 0;
    int   nb;
    logic hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp;
    for (int c = 0; c < 30000 && (sent < 1000 || sb.size() > 0); c++) begin
      @(negedge rclk);
      m_tready = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      for (int k = 0; k < nb; k++) begin
        if (sent < 1000 && 5'(wbin - rbin) < 5'd16) begin
          push_word(8'($urandom));
          sent++;
        end
      end
      #1;
      if (hold_prev) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
          n_fail++;
          $display("FAIL rand_stable: tvalid=%b tdata=%h required 1 %h", m_tvalid, m_tdata, prev_data);
        end
      end
      hold_prev = m_tvalid && !m_tready;
      prev_data = m_tdata;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got %h, required no word", m_tdata);
        end else begin
          exp = sb.pop_front();
          recv++;
          if (m_tdata !== exp) begin
            n_fail++;
            $display("FAIL rand_data: word %0d got %h required %h", recv, m_tdata, exp);
          end
        end
      end
    end
    n_checks++;
    if (sent != 1000 || recv != 1000 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent=%0d recv=%0d left=%0d required 1000 1000 0", sent, recv, sb.size());
    end
  endtask

  task automatic test_level_wrap();
    logic [4:0] lw [6];
    logic [4:0] lr [6];
    logic [4:0] ll [6];
    logic       la [6];
    logic [4:0] prev = 5'd0;
    lw = '{5'h02, 5'h00, 5'h01, 5'h0E, 5'h1E, 5'h13};
    lr = '{5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h0F};
    ll = '{5'd4,  5'd2,  5'd3,  5'd16, 5'd0,  5'd4};
    la = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      manual = 1'b1;
      man_w  = gray(lw[i]);
      man_r  = gray(lr[i]);
      #1;
      n_checks++;
      if (rlevel !== prev) begin
        n_fail++;
        $display("FAIL level_lag[%0d]: got %0d required %0d", i, rlevel, prev);
      end
      @(negedge rclk);
      #1;
      n_checks++;
      if (rlevel !== ll[i] || ralmost_empty !== la[i]) begin
        n_fail++;
        $display("FAIL level[%0d]: rlevel=%0d ae=%b required %0d %b", i, rlevel, ralmost_empty, ll[i], la[i]);
      end
      prev = ll[i];
    end
    @(negedge rclk);
    manual = 1'b0;
  endtask

  task automatic test_mid_reset();
    int got = 0;
    logic [7:0] exp;
    @(negedge rclk);
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
    repeat (8) @(negedge rclk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b1 || rinc !== 1'b0 || rempty !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_s2: tvalid=%b rinc=%b rempty=%b required 1 0 0", m_tvalid, rinc, rempty);
    end
    #2;
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: tvalid=%b tdata=%h rinc=%b required 0 00 0", m_tvalid, m_tdata, rinc);
    end
    wbin = '0;
    sb.delete();
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || rlevel !== 5'd0 || ralmost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after: tvalid=%b rlevel=%0d ae=%b required 0 0 1", m_tvalid, rlevel, ralmost_empty);
    end
    @(negedge rclk);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(8'h61 + 8'(i));
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      #1;
      if (m_tvalid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mid_extra: got %h, required no word", m_tdata);
        end else begin
          exp = sb.pop_front();
          got++;
          if (m_tdata !== exp) begin
            n_fail++;
            $display("FAIL mid_data: got %h required %h", m_tdata, exp);
          end
        end
      end
    end
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL mid_count: got %0d words required 3", got);
    end
  endtask

  initial begin
    rrst_n   = 1'b0;
    m_tready = 1'b0;
    manual   = 1'b0;
    man_r    = '0;
    man_w    = '0;
    wbin     = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_ready();
    test_level_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule
